weight_column_sequencer: RTL

//  Sequences the column-weight ROM for one neuron pass. On start it steps the ROM address
//  0..cnt-1 and captures each N*n weight column into an output register. It then streams the

---
 rtl/nn_pkg.sv | 23 ++
 rtl/weight_column_sequencer_out_reg.sv | 37 +++
 rtl/weight_column_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared parameters and FSM encoding for the neuron weight path.
package nn_pkg;
  localparam int N  = 8;   // weights per column (MAC lanes)
  localparam int S  = 8;   // columns stored in ROM
  localparam int n  = 32;  // bits per weight, Q16.16
  localparam int AW = 3;   // ROM address width, S <= 2**AW
  localparam int CW = N * n;

  localparam logic [AW:0] S_CNT = (AW+1)'(S);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // A request of zero or more than S columns means a full pass.
  function automatic logic [AW:0] clamp_cols(input logic [AW:0] nc);
    if (nc == '0 || nc > S_CNT) return S_CNT;
    return nc;
  endfunction
endpackage

// File: rtl/weight_column_sequencer_out_reg.sv
// Output stage: load-enabled weight column, column index and last flag with a valid bit.
module wcs_out_reg
  import nn_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          consume,
  input  logic [CW-1:0] d,
  input  logic [AW-1:0] col_d,
  input  logic          last_d,
  output logic [CW-1:0] data,
  output logic [AW-1:0] col,
  output logic          last,
  output logic          valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      col   <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (flush) begin
      // Data and column are left stale; only the qualifiers drop.
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= d;
      col   <= col_d;
      last  <= last_d;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/weight_column_sequencer.sv
// Steps the column-weight ROM for one neuron pass and streams each column to the MAC array.
module weight_column_sequencer
  import nn_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   num_cols,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [CW-1:0] rom_w,
  output logic [CW-1:0] w_data,
  output logic [AW-1:0] w_col,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          w_last,
  output logic          busy,
  output logic          done,
  output state_t        dbg_state
);
  // Handshake: a beat transfers on a cycle where w_valid && w_ready; while w_valid is high
  // and w_ready low, w_data/w_col/w_last hold and w_valid never drops except on abort/rst.
  state_t      state;
  logic [AW:0] cnt;
  logic [AW:0] issue_ctr;
  logic        load;
  logic        consume;
  logic        is_last;

  assign is_last   = (issue_ctr == cnt - 1'b1);
  assign load      = (state == ST_RUN) && (!w_valid || w_ready);
  assign consume   = (state == ST_DRAIN) && w_valid && w_ready;
  assign rom_addr  = (state == ST_RUN) ? issue_ctr[AW-1:0] : '0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      issue_ctr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      issue_ctr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt       <= clamp_cols(num_cols);
            issue_ctr <= '0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load) begin
            issue_ctr <= issue_ctr + 1'b1;
            if (is_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (consume) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wcs_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .load    (load),
    .consume (consume),
    .d       (rom_w),
    .col_d   (issue_ctr[AW-1:0]),
    .last_d  (is_last),
    .data    (w_data),
    .col     (w_col),
    .last    (w_last),
    .valid   (w_valid)
  );
endmodule
